// File: rtl/arf132b064e1r1w0cbbehbaa4acw_rcb_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module : arf132b064e1r1w0cbbehbaa4acw_rcb_ctrl_pkg
// Purpose: Shared types and defaults for the RCB power/clock-enable
//          sequencer: FSM state encoding, default counter widths and the
//          reset value of the LCP {Fd,Rd} configuration.
// Ports  : none (package)
// Rev    : 1.0  initial release
// ============================================================================
package arf132b064e1r1w0cbbehbaa4acw_rcb_ctrl_pkg;

  // Default widths of the idle and wake counters.
  localparam int RCB_IDLE_W = 8;
  localparam int RCB_WAKE_W = 4;

  // Reset value of {Fd,Rd}.
  localparam logic [1:0] RCB_LCP_RST = 2'b00;

  // Sequencer states; encoding 2'd3 is illegal and recovers to ST_OFF.
  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_WAKE = 2'd1,
    ST_ON   = 2'd2
  } rcb_state_e;

endpackage
`default_nettype wire

// File: rtl/arf132b064e1r1w0cbbehbaa4acw_rcb_pwr_ctrl.sv
`default_nettype none
// ============================================================================
// Module : arf132b064e1r1w0cbbehbaa4acw_rcb_pwr_ctrl
// Purpose: Regional power/clock-enable sequencer for the array RCB. Wakes the
//          region on request, waits a programmable wake latency before
//          raising Ready, auto-gates after a programmable idle period, and
//          defers LCP {Fd,Rd} updates until the region is gated.
// Ports  :
//   CkGridX1N      in   grid clock
//   RstN           in   async active-low reset
//   ReqVld         in   per-requester activity request
//   Ready          out  region clock usable (state ON)
//   CfgIdleThresh  in   idle cycles in ON before gating, 0 = never
//   CfgWakeLat     in   extra WAKE cycles
//   CfgOvrd        in   override request (blocks auto-gating)
//   CfgLcpVld      in   strobe capturing CfgLcp
//   CfgLcp         in   new {Fd,Rd}
//   FscanClkUngate in   scan ungate, freezes the controller
//   RPEn           out  regional power enable (WAKE or ON)
//   RPOvrd         out  registered copy of CfgOvrd
//   Fd, Rd         out  LCP bits
//   LcpPend        out  LCP update captured, not yet applied
//   State          out  FSM state for debug
// Rev    : 1.0  initial release
// ============================================================================
module arf132b064e1r1w0cbbehbaa4acw_rcb_pwr_ctrl
  import arf132b064e1r1w0cbbehbaa4acw_rcb_ctrl_pkg::*;
#(
  parameter int         NUM_REQ = 2,
  parameter int         IDLE_W  = RCB_IDLE_W,
  parameter int         WAKE_W  = RCB_WAKE_W,
  parameter logic [1:0] LCP_RST = RCB_LCP_RST
) (
  input  logic               CkGridX1N,
  input  logic               RstN,
  input  logic [NUM_REQ-1:0] ReqVld,
  output logic               Ready,
  input  logic [IDLE_W-1:0]  CfgIdleThresh,
  input  logic [WAKE_W-1:0]  CfgWakeLat,
  input  logic               CfgOvrd,
  input  logic               CfgLcpVld,
  input  logic [1:0]         CfgLcp,
  input  logic               FscanClkUngate,
  output logic               RPEn,
  output logic               RPOvrd,
  output logic               Fd,
  output logic               Rd,
  output logic               LcpPend,
  output logic [1:0]         State
);

  rcb_state_e        state;
  rcb_state_e        state_nxt;
  logic [IDLE_W-1:0] idle_cnt;
  logic [IDLE_W-1:0] idle_nxt;
  logic [WAKE_W-1:0] wake_cnt;
  logic [WAKE_W-1:0] wake_nxt;
  logic [1:0]        lcp_q;
  logic [1:0]        lcp_pend_val;
  logic              lcp_pend;
  logic              lcp_apply;
  logic              any_req;
  logic              state_legal;

  assign any_req     = |ReqVld;
  assign state_legal = (state == ST_OFF) || (state == ST_WAKE) || (state == ST_ON);

  // LCP bits may only change while the region is gated and not frozen.
  assign lcp_apply = lcp_pend && (state == ST_OFF) && !FscanClkUngate;

  // Outputs decode straight from registers: no input-to-output paths.
  assign State   = state;
  assign RPEn    = (state == ST_WAKE) || (state == ST_ON);
  assign Ready   = (state == ST_ON);
  assign Fd      = lcp_q[1];
  assign Rd      = lcp_q[0];
  assign LcpPend = lcp_pend;

  always_comb begin
    state_nxt = state;
    idle_nxt  = idle_cnt;
    wake_nxt  = wake_cnt;
    if (!state_legal) begin
      // Recovery from the unused encoding is not subject to scan freeze.
      state_nxt = ST_OFF;
      idle_nxt  = '0;
      wake_nxt  = '0;
    end else if (!FscanClkUngate) begin
      case (state)
        ST_OFF: begin
          if (any_req) begin
            state_nxt = ST_WAKE;
            wake_nxt  = CfgWakeLat;
          end
        end
        ST_WAKE: begin
          if (wake_cnt == '0) begin
            state_nxt = ST_ON;
            idle_nxt  = '0;
          end else begin
            wake_nxt = wake_cnt - 1'b1;
          end
        end
        ST_ON: begin
          if (any_req) begin
            // A request always beats a coincident threshold hit.
            idle_nxt = '0;
          end else if (CfgOvrd) begin
            idle_nxt = idle_cnt;
          end else if ((CfgIdleThresh != '0) && (idle_cnt == CfgIdleThresh)) begin
            state_nxt = ST_OFF;
          end else if (idle_cnt != '1) begin
            idle_nxt = idle_cnt + 1'b1;
          end
        end
        default: begin
          state_nxt = ST_OFF;
        end
      endcase
    end
  end

  always_ff @(posedge CkGridX1N or negedge RstN) begin
    if (!RstN) begin
      state        <= ST_OFF;
      idle_cnt     <= '0;
      wake_cnt     <= '0;
      RPOvrd       <= 1'b0;
      lcp_q        <= LCP_RST;
      lcp_pend_val <= LCP_RST;
      lcp_pend     <= 1'b0;
    end else begin
      state    <= state_nxt;
      idle_cnt <= idle_nxt;
      wake_cnt <= wake_nxt;
      if (!FscanClkUngate) begin
        RPOvrd <= CfgOvrd;
      end
      if (lcp_apply) begin
        lcp_q <= lcp_pend_val;
      end
      // Capture keeps working under scan freeze; a new strobe on the apply
      // edge stays pending while the older value is applied.
      if (CfgLcpVld) begin
        lcp_pend_val <= CfgLcp;
        lcp_pend     <= 1'b1;
      end else if (lcp_apply) begin
        lcp_pend <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_arf132b064e1r1w0cbbehbaa4acw_rcb_pwr_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_arf132b064e1r1w0cbbehbaa4acw_rcb_pwr_ctrl
// Purpose: Self-checking bench for the RCB power sequencer: a directed
//          vector table, hand sequences for freeze / async reset /
//          saturation, and randomized traffic against a timestamp model.
// Ports  : none
// Rev    : 1.0  initial release
// ============================================================================
module tb_arf132b064e1r1w0cbbehbaa4acw_rcb_pwr_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] req;
  logic [7:0] thr;
  logic [3:0] wlat;
  logic       ovrd;
  logic       lv;
  logic [1:0] lcp;
  logic       scan;

  logic       ready, rpen, rpovrd, fd, rd, pend;
  logic [1:0] state;

  always #5 clk = ~clk;

  arf132b064e1r1w0cbbehbaa4acw_rcb_pwr_ctrl dut (
    .CkGridX1N     (clk),
    .RstN          (rst_n),
    .ReqVld        (req),
    .Ready         (ready),
    .CfgIdleThresh (thr),
    .CfgWakeLat    (wlat),
    .CfgOvrd       (ovrd),
    .CfgLcpVld     (lv),
    .CfgLcp        (lcp),
    .FscanClkUngate(scan),
    .RPEn          (rpen),
    .RPOvrd        (rpovrd),
    .Fd            (fd),
    .Rd            (rd),
    .LcpPend       (pend),
    .State         (state)
  );

  int n_total = 0;
  int n_pass  = 0;

  wire [7:0] dut_vec = {state, rpen, ready, rpovrd, fd, rd, pend};

  // Expected output vector from the spec-level quantities.
  function automatic logic [7:0] pack_exp(logic [1:0] st, logic rpo, logic [1:0] fdrd, logic pd);
    return {st, (st != 2'd0), (st == 2'd2), rpo, fdrd, pd};
  endfunction

  task automatic check(string name, logic [7:0] act, logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual={st,rpen,rdy,ovr,fd,rd,pend}=%b required=%b", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req = 2'b00; ovrd = 1'b0; lv = 1'b0; lcp = 2'b00; scan = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [1:0] req;
    logic [7:0] thr;
    logic       ovrd;
    logic       lv;
    logic [1:0] lcp;
    logic [1:0] est;
    logic       erpo;
    logic [1:0] efd;
    logic       epend;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(int n, logic [1:0] r, logic [7:0] t, logic o, logic v, logic [1:0] l,
                              logic [1:0] st, logic rpo, logic [1:0] f, logic pd);
    vec_t e;
    e = '{r, t, o, v, l, st, rpo, f, pd};
    for (int i = 0; i < n; i++) vecs.push_back(e);
  endfunction

  // ---------------- behavioural reference model ----------------
  localparam int M_OFF = 0, M_WAKE = 1, M_ON = 2;
  int         m_st;
  int         m_cyc;
  int         m_on_edge;   // edge number at which WAKE becomes ON
  int         m_idle;      // quiet ON cycles since entry or last request
  logic       m_rpo;
  logic [1:0] m_fd;
  logic       m_pend;
  logic [1:0] m_pval;

  function automatic void model_reset();
    m_st = M_OFF; m_cyc = 0; m_on_edge = 0; m_idle = 0;
    m_rpo = 1'b0; m_fd = 2'b00; m_pend = 1'b0; m_pval = 2'b00;
  endfunction

  function automatic void model_tick();
    logic apply;
    apply = !scan && (m_st == M_OFF) && m_pend;
    if (apply) m_fd = m_pval;
    if (lv) begin
      m_pval = lcp;
      m_pend = 1'b1;
    end else if (apply) begin
      m_pend = 1'b0;
    end
    if (scan) begin
      if (m_st == M_WAKE) m_on_edge++;   // frozen edge postpones Ready
    end else begin
      m_rpo = ovrd;
      if (m_st == M_OFF) begin
        if (req != 2'b00) begin
          m_st      = M_WAKE;
          m_on_edge = m_cyc + 1 + int'(wlat);
        end
      end else if (m_st == M_WAKE) begin
        if (m_cyc == m_on_edge) begin
          m_st   = M_ON;
          m_idle = 0;
        end
      end else begin
        if (req != 2'b00) m_idle = 0;
        else if (!ovrd) begin
          if (thr != 0 && m_idle == int'(thr)) m_st = M_OFF;
          else if (m_idle < 255) m_idle++;
        end
      end
    end
    m_cyc++;
  endfunction

  function automatic logic [7:0] model_vec();
    return pack_exp(2'(m_st), m_rpo, m_fd, m_pend);
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    rst_n = 1'b0;
    thr   = 8'd4;
    wlat  = 4'd3;
    idle_inputs();
    do_reset();
    check("reset", dut_vec, 8'h00);

    // Cold wake, idle gate with deferred LCP, request on threshold cycle.
    add(1, 2'b01, 8'd4, 0, 0, 2'b00, 2'd1, 0, 2'b00, 0);
    add(3, 2'b00, 8'd4, 0, 0, 2'b00, 2'd1, 0, 2'b00, 0);
    add(1, 2'b00, 8'd4, 0, 0, 2'b00, 2'd2, 0, 2'b00, 0);
    add(1, 2'b00, 8'd4, 0, 1, 2'b10, 2'd2, 0, 2'b00, 1);
    add(3, 2'b00, 8'd4, 0, 0, 2'b00, 2'd2, 0, 2'b00, 1);
    add(1, 2'b00, 8'd4, 0, 0, 2'b00, 2'd0, 0, 2'b00, 1);
    add(1, 2'b00, 8'd4, 0, 0, 2'b00, 2'd0, 0, 2'b10, 0);
    add(1, 2'b10, 8'd4, 0, 0, 2'b00, 2'd1, 0, 2'b10, 0);
    add(3, 2'b00, 8'd4, 0, 0, 2'b00, 2'd1, 0, 2'b10, 0);
    add(5, 2'b00, 8'd4, 0, 0, 2'b00, 2'd2, 0, 2'b10, 0);
    add(1, 2'b10, 8'd4, 0, 0, 2'b00, 2'd2, 0, 2'b10, 0);
    add(4, 2'b00, 8'd4, 0, 0, 2'b00, 2'd2, 0, 2'b10, 0);
    add(1, 2'b00, 8'd4, 0, 0, 2'b00, 2'd0, 0, 2'b10, 0);
    // Override blocks idle exit; release gates three edges later.
    add(1, 2'b01, 8'd2, 0, 0, 2'b00, 2'd1, 0, 2'b10, 0);
    add(3, 2'b00, 8'd2, 0, 0, 2'b00, 2'd1, 0, 2'b10, 0);
    add(1, 2'b00, 8'd2, 0, 0, 2'b00, 2'd2, 0, 2'b10, 0);
    add(20, 2'b00, 8'd2, 1, 0, 2'b00, 2'd2, 1, 2'b10, 0);
    add(2, 2'b00, 8'd2, 0, 0, 2'b00, 2'd2, 0, 2'b10, 0);
    add(1, 2'b00, 8'd2, 0, 0, 2'b00, 2'd0, 0, 2'b10, 0);
    // LCP in OFF: one-edge apply, strobe colliding with apply, apply on wake edge.
    add(1, 2'b00, 8'd2, 0, 1, 2'b01, 2'd0, 0, 2'b10, 1);
    add(1, 2'b00, 8'd2, 0, 0, 2'b00, 2'd0, 0, 2'b01, 0);
    add(1, 2'b00, 8'd2, 0, 1, 2'b11, 2'd0, 0, 2'b01, 1);
    add(1, 2'b00, 8'd2, 0, 1, 2'b00, 2'd0, 0, 2'b11, 1);
    add(1, 2'b00, 8'd2, 0, 0, 2'b00, 2'd0, 0, 2'b00, 0);
    add(1, 2'b00, 8'd2, 0, 1, 2'b10, 2'd0, 0, 2'b00, 1);
    add(1, 2'b01, 8'd2, 0, 0, 2'b00, 2'd1, 0, 2'b10, 0);
    add(3, 2'b00, 8'd2, 0, 0, 2'b00, 2'd1, 0, 2'b10, 0);
    add(1, 2'b00, 8'd2, 0, 0, 2'b00, 2'd2, 0, 2'b10, 0);

    wlat = 4'd3;
    foreach (vecs[i]) begin
      req = vecs[i].req; thr = vecs[i].thr; ovrd = vecs[i].ovrd;
      lv  = vecs[i].lv;  lcp = vecs[i].lcp; scan = 1'b0;
      step();
      check($sformatf("vec%0d", i), dut_vec,
            pack_exp(vecs[i].est, vecs[i].erpo, vecs[i].efd, vecs[i].epend));
    end

    // Async reset mid-WAKE with override and a pending LCP value.
    idle_inputs();
    thr = 8'd1;
    repeat (6) step();
    check("gate_before_rst", dut_vec, pack_exp(2'd0, 0, 2'b10, 0));
    req = 2'b01; ovrd = 1'b1; wlat = 4'd3;
    step();
    req = 2'b00; lv = 1'b1; lcp = 2'b11;
    step();
    lv = 1'b0;
    check("pre_rst", dut_vec, pack_exp(2'd1, 1, 2'b10, 1));
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst", dut_vec, 8'h00);
    ovrd = 1'b0;
    step();
    rst_n = 1'b1;
    req = 2'b01;
    step();
    req = 2'b00;
    check("rewake_0", dut_vec, pack_exp(2'd1, 0, 2'b00, 0));
    for (int i = 1; i <= 3; i++) begin
      step();
      check($sformatf("rewake_%0d", i), dut_vec, pack_exp(2'd1, 0, 2'b00, 0));
    end
    step();
    check("rewake_ready", dut_vec, pack_exp(2'd2, 0, 2'b00, 0));

    // Idle counter saturation: with threshold 0 it never gates, then a
    // threshold of 255 must match the saturated count on the next edge.
    thr = 8'd0;
    repeat (300) step();
    check("sat_hold", dut_vec, pack_exp(2'd2, 0, 2'b00, 0));
    thr = 8'd255;
    step();
    check("sat_exit", dut_vec, pack_exp(2'd0, 0, 2'b00, 0));

    // Scan freeze mid-WAKE; capture still runs, the wake count resumes.
    do_reset();
    wlat = 4'd5;
    req  = 2'b01;
    step();
    req = 2'b00;
    step();
    step();
    scan = 1'b1; lv = 1'b1; lcp = 2'b11;
    for (int i = 0; i < 10; i++) begin
      step();
      lv = 1'b0;
      check($sformatf("freeze_%0d", i), dut_vec, pack_exp(2'd1, 0, 2'b00, 1));
    end
    scan = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("resume_%0d", i), dut_vec, pack_exp(2'd1, 0, 2'b00, 1));
    end
    step();
    check("resume_ready", dut_vec, pack_exp(2'd2, 0, 2'b00, 1));

    // Randomized traffic against the reference model.
    do_reset();
    model_reset();
    thr = 8'd3; wlat = 4'd1;
    for (int i = 0; i < 3000; i++) begin
      req = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      if ($urandom_range(0, 49) == 0) thr  = 8'($urandom_range(0, 6));
      if ($urandom_range(0, 29) == 0) wlat = 4'($urandom_range(0, 4));
      if ($urandom_range(0, 39) == 0) ovrd = ~ovrd;
      lv  = ($urandom_range(0, 14) == 0);
      lcp = 2'($urandom_range(0, 3));
      if (scan) scan = ($urandom_range(0, 4) != 0);
      else      scan = ($urandom_range(0, 79) == 0);
      model_tick();
      step();
      check($sformatf("rand%0d", i), dut_vec, model_vec());
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
